// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv_frame_streamer slice: the streamer
// FSM state encoding, an output-size helper and a default pixel type.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int PIXEL_W = 8;
  typedef logic [PIXEL_W-1:0] pixel_t;

  // Side of a "valid" (no padding) convolution output.
  function automatic int calc_output_size(input int input_size, input int kernel_size);
    return input_size - (kernel_size - 1);
  endfunction

endpackage

// File: rtl/conv_layer.sv
// Combinational valid-mode 2D convolution over a packed frame.
// Each output pixel is the unsigned sum of products over the kernel window
// and all channels, divided by 8 and truncated to PX_SIZE bits.
module conv_layer
  import conv_pkg::*;
#(
  parameter int INPUT_SIZE     = 5,
  parameter int INPUT_CHANNELS = 1,
  parameter int KERNEL_SIZE    = 3,
  parameter int PX_SIZE        = 8
) (
  input  logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0]    img,
  input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0]  kernel,
  output logic [INPUT_SIZE-KERNEL_SIZE:0][INPUT_SIZE-KERNEL_SIZE:0][PX_SIZE-1:0]    out_frame
);

  localparam int OUTPUT_SIZE = calc_output_size(INPUT_SIZE, KERNEL_SIZE);
  localparam int ACC_W       = 2*PX_SIZE + $clog2(KERNEL_SIZE*KERNEL_SIZE*INPUT_CHANNELS) + 1;

  // Scale the accumulated window sum back to pixel range (divide by 8, truncate).
  function automatic logic [PX_SIZE-1:0] scale_px(input logic [ACC_W-1:0] acc);
    return PX_SIZE'(acc >> 3);
  endfunction

  for (genvar r = 0; r < OUTPUT_SIZE; r++) begin : g_row
    for (genvar c = 0; c < OUTPUT_SIZE; c++) begin : g_col
      logic [ACC_W-1:0] acc;

      // Multiply-accumulate over the KxK window and all channels.
      always_comb begin
        acc = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
          for (int j = 0; j < KERNEL_SIZE; j++) begin
            for (int ch = 0; ch < INPUT_CHANNELS; ch++) begin
              acc = acc + ACC_W'(img[r+i][c+j][ch]) * ACC_W'(kernel[i][j][ch]);
            end
          end
        end
      end

      assign out_frame[r][c] = scale_px(acc);
    end
  end

endmodule

// File: rtl/conv_frame_streamer.sv
// Streaming wrapper around conv_layer: collects a raster-order pixel stream
// into a frame buffer, registers the convolution result in one cycle, then
// drains the result pixels over a valid/ready interface.
// Optional build macro CONV_FRAME_STREAMER_LAST_EN adds an out_last port
// flagging the final output pixel of each frame.
module conv_frame_streamer
  import conv_pkg::*;
#(
  parameter int INPUT_SIZE     = 5,
  parameter int INPUT_CHANNELS = 1,
  parameter int KERNEL_SIZE    = 3,
  parameter int PX_SIZE        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] kernel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PX_SIZE-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PX_SIZE-1:0]  out_data,
  output logic                busy
`ifdef CONV_FRAME_STREAMER_LAST_EN
  ,
  output logic                out_last
`endif
);

  localparam int OUTPUT_SIZE = calc_output_size(INPUT_SIZE, KERNEL_SIZE);
  localparam int CW          = $clog2(INPUT_SIZE*INPUT_CHANNELS + 1);

  typedef logic [INPUT_SIZE-1:0][INPUT_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0]   img_t;
  typedef logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][INPUT_CHANNELS-1:0][PX_SIZE-1:0] ker_t;
  typedef logic [OUTPUT_SIZE-1:0][OUTPUT_SIZE-1:0][PX_SIZE-1:0]                     res_t;

  state_t          state;
  logic [CW-1:0]   in_row, in_col, in_ch;
  logic [CW-1:0]   out_row, out_col;
  img_t            img_buf;
  ker_t            kernel_reg;
  res_t            conv_out;
  res_t            out_buf;
  logic            in_fire, in_first, in_last, out_final;

  assign in_ready  = !rst && (state == LOAD);
  assign in_fire   = in_valid && in_ready;
  assign in_first  = (in_row == '0) && (in_col == '0) && (in_ch == '0);
  assign in_last   = (in_row == CW'(INPUT_SIZE-1)) && (in_col == CW'(INPUT_SIZE-1)) &&
                     (in_ch == CW'(INPUT_CHANNELS-1));
  assign out_final = (out_row == CW'(OUTPUT_SIZE-1)) && (out_col == CW'(OUTPUT_SIZE-1));
  assign out_valid = (state == DRAIN);
  assign busy      = (state != LOAD);
`ifdef CONV_FRAME_STREAMER_LAST_EN
  assign out_last  = (state == DRAIN) && out_final;
`endif

  conv_layer #(
    .INPUT_SIZE     (INPUT_SIZE),
    .INPUT_CHANNELS (INPUT_CHANNELS),
    .KERNEL_SIZE    (KERNEL_SIZE),
    .PX_SIZE        (PX_SIZE)
  ) u_conv_layer (
    .img       (img_buf),
    .kernel    (kernel_reg),
    .out_frame (conv_out)
  );

  // Frame sequencing: raster counters for load and drain, and state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      in_row  <= '0;
      in_col  <= '0;
      in_ch   <= '0;
      out_row <= '0;
      out_col <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            if (in_ch == CW'(INPUT_CHANNELS-1)) begin
              in_ch <= '0;
              if (in_col == CW'(INPUT_SIZE-1)) begin
                in_col <= '0;
                in_row <= (in_row == CW'(INPUT_SIZE-1)) ? '0 : in_row + CW'(1);
              end else begin
                in_col <= in_col + CW'(1);
              end
            end else begin
              in_ch <= in_ch + CW'(1);
            end
            if (in_last) state <= CAPTURE;
          end
        end
        CAPTURE: state <= DRAIN;
        DRAIN: begin
          if (out_ready) begin
            if (out_col == CW'(OUTPUT_SIZE-1)) begin
              out_col <= '0;
              out_row <= (out_row == CW'(OUTPUT_SIZE-1)) ? '0 : out_row + CW'(1);
            end else begin
              out_col <= out_col + CW'(1);
            end
            if (out_final) state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Input frame and kernel capture; plain data storage with no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (in_first) kernel_reg <= kernel;
      for (int r = 0; r < INPUT_SIZE; r++) begin
        for (int c = 0; c < INPUT_SIZE; c++) begin
          for (int ch = 0; ch < INPUT_CHANNELS; ch++) begin
            if ((in_row == CW'(r)) && (in_col == CW'(c)) && (in_ch == CW'(ch)))
              img_buf[r][c][ch] <= in_data;
          end
        end
      end
    end
  end

  // Result frame register, loaded once per frame in CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_buf <= '0;
    end else if (state == CAPTURE) begin
      out_buf <= conv_out;
    end
  end

  // Select the current drain pixel from the result frame.
  always_comb begin
    out_data = '0;
    for (int r = 0; r < OUTPUT_SIZE; r++) begin
      for (int c = 0; c < OUTPUT_SIZE; c++) begin
        if ((out_row == CW'(r)) && (out_col == CW'(c))) out_data = out_buf[r][c];
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_streamer.sv
// Testbench for conv_frame_streamer (default parameters: 5x5x1 input, 3x3 kernel).
module tb_conv_frame_streamer;

  localparam int IS = 5;
  localparam int KS = 3;
  localparam int OS = IS - KS + 1;
  localparam int NIN = IS*IS;
  localparam int NOUT = OS*OS;

  logic clk;
  logic rst;
  logic [KS-1:0][KS-1:0][0:0][7:0] kernel;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [7:0] out_data;
  logic busy;
`ifdef CONV_FRAME_STREAMER_LAST_EN
  logic out_last;
`endif

  conv_frame_streamer #(
    .INPUT_SIZE(IS), .INPUT_CHANNELS(1), .KERNEL_SIZE(KS), .PX_SIZE(8)
  ) dut (
    .clk(clk), .rst(rst), .kernel(kernel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
`ifdef CONV_FRAME_STREAMER_LAST_EN
    , .out_last(out_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  int img_v[NIN];
  int ker_v[KS*KS];
  int exp_v[NOUT];

  typedef struct {
    int px;      // every input pixel
    int kv;      // every kernel weight
    int stall;   // 0 none, 1 pattern 1,0,0, 2 random gaps/stalls
    int exp_px;  // every output pixel
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: valid-mode convolution with plain integer arithmetic.
  task automatic model();
    for (int r = 0; r < OS; r++)
      for (int c = 0; c < OS; c++) begin
        int s;
        s = 0;
        for (int i = 0; i < KS; i++)
          for (int j = 0; j < KS; j++)
            s += img_v[(r+i)*IS + c + j] * ker_v[i*KS + j];
        exp_v[r*OS + c] = (s / 8) % 256;
      end
  endtask

  // ker_mode: 0 keep kernel, 1 all-zero from beat 5, 2 random garbage from beat 1.
  task automatic drive_kernel(input int k, input int ker_mode);
    for (int i = 0; i < KS; i++)
      for (int j = 0; j < KS; j++) begin
        if (k == 0 || ker_mode == 0 || (ker_mode == 1 && k < 5))
          kernel[i][j][0] = 8'(ker_v[i*KS + j]);
        else if (ker_mode == 1)
          kernel[i][j][0] = 8'd0;
        else
          kernel[i][j][0] = 8'($urandom_range(0, 255));
      end
  endtask

  task automatic load_beats(input int n, input int ker_mode, input bit gaps);
    int k;
    int guard;
    bit fire;
    k = 0;
    guard = 0;
    while (k < n && guard < 500) begin
      chk("in_ready_load", in_ready, 1);
      chk("out_valid_load", out_valid, 0);
`ifdef CONV_FRAME_STREAMER_LAST_EN
      chk("out_last_load", out_last, 0);
`endif
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = 8'(img_v[k]);
      drive_kernel(k, ker_mode);
      fire = in_valid && in_ready;
      step();
      if (fire) k++;
      guard++;
    end
    in_valid = 1'b0;
    in_data = 8'($urandom_range(0, 255));
    chk("load_beats", k, n);
  endtask

  task automatic run_frame(input int stall_mode, input int ker_mode);
    int idx;
    int guard;
    int ph;
    bit fire;
    load_beats(NIN, ker_mode, stall_mode == 2);
    // cycle N+1: CAPTURE
    chk("capture_out_valid", out_valid, 0);
    chk("capture_in_ready", in_ready, 0);
    chk("capture_busy", busy, 1);
    in_valid = 1'b1;  // must be ignored while busy
    step();
    // cycle N+2: first output pixel
    chk("first_out_valid", out_valid, 1);
    idx = 0;
    guard = 0;
    ph = 0;
    while (idx < NOUT && guard < 300) begin
      chk("drain_out_valid", out_valid, 1);
      chk("drain_out_data", out_data, exp_v[idx]);
      chk("drain_in_ready", in_ready, 0);
      chk("drain_busy", busy, 1);
`ifdef CONV_FRAME_STREAMER_LAST_EN
      chk("drain_out_last", out_last, (idx == NOUT-1) ? 1 : 0);
`endif
      case (stall_mode)
        0: out_ready = 1'b1;
        1: out_ready = (ph % 3 == 0);
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      in_valid = ($urandom_range(0, 1) == 1);
      ph++;
      fire = out_ready;
      step();
      if (fire) idx++;
      guard++;
    end
    chk("drain_beats", idx, NOUT);
    if (stall_mode == 0) chk("drain_cycles_no_bp", guard, NOUT);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  task automatic fill_const(input int px, input int kv, input int ex);
    for (int i = 0; i < NIN; i++) img_v[i] = px;
    for (int i = 0; i < KS*KS; i++) ker_v[i] = kv;
    for (int i = 0; i < NOUT; i++) exp_v[i] = ex;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{px: 1,   kv: 1,   stall: 0, exp_px: 1};
    tbl[1] = '{px: 8,   kv: 1,   stall: 0, exp_px: 9};
    tbl[2] = '{px: 1,   kv: 1,   stall: 1, exp_px: 1};
    tbl[3] = '{px: 4,   kv: 2,   stall: 0, exp_px: 9};
    tbl[4] = '{px: 255, kv: 255, stall: 1, exp_px: 193};
    tbl[5] = '{px: 20,  kv: 3,   stall: 2, exp_px: 67};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    out_ready = 1'b0;
    kernel = '0;
    step();
    step();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
`ifdef CONV_FRAME_STREAMER_LAST_EN
    chk("reset_out_last", out_last, 0);
`endif
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Table-driven constant frames
    for (int t = 0; t < 6; t++) begin
      fill_const(tbl[t].px, tbl[t].kv, tbl[t].exp_px);
      run_frame(tbl[t].stall, 0);
    end

    // Kernel latched on beat 0 only: zero kernel from beat 5 onward is ignored
    fill_const(1, 1, 1);
    run_frame(0, 1);

    // Reset after beat 12 discards the partial frame
    fill_const(200, 7, 0);
    load_beats(13, 0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("midreset_in_ready", in_ready, 0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready_after", in_ready, 1);
    fill_const(1, 1, 1);
    run_frame(0, 0);

    // Reset in the middle of a drain
    fill_const(8, 1, 9);
    load_beats(NIN, 0, 1'b0);
    step();
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("drain_reset_out_valid", out_valid, 0);
    chk("drain_reset_out_data", out_data, 0);
    chk("drain_reset_in_ready", in_ready, 1);
    fill_const(1, 1, 1);
    run_frame(1, 0);

    // Randomized frames against the reference model
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < NIN; i++) img_v[i] = $urandom_range(0, 255);
      for (int i = 0; i < KS*KS; i++) ker_v[i] = $urandom_range(0, 255);
      model();
      run_frame(2, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
